// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between the fetch stage and decode.
// Holds {instr, pc, pred_taken} entries in a small circular buffer with
// first-word fall-through on the head. Flush discards every entry.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   flush_i              discard all entries (mispredict / redirect)
//   enq_valid_i/ready_o  fetch-side handshake
//   enq_instr_i/pc_i/pred_taken_i   entry written at the tail
//   deq_valid_o/ready_i  decode-side handshake
//   deq_instr_o/pc_o/pred_taken_o   head entry, NOP/0/0 when not valid
//   count_o              occupancy, 0..DEPTH
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_W     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             enq_valid_i,
    output logic             enq_ready_o,
    input  logic [31:0]      enq_instr_i,
    input  logic [31:0]      enq_pc_i,
    input  logic             enq_pred_taken_i,
    output logic             deq_valid_o,
    input  logic             deq_ready_i,
    output logic [31:0]      deq_instr_o,
    output logic [31:0]      deq_pc_o,
    output logic             deq_pred_taken_o,
    output logic [PTR_W:0]   count_o
);

    localparam int unsigned   CNT_W    = PTR_W + 1;
    localparam logic [PTR_W:0]   FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // Storage is deliberately left out of reset; validity comes from count_q.
    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] pc_mem_q    [DEPTH];
    logic        taken_mem_q [DEPTH];

    logic enq_fire;
    logic deq_fire;

    // Ready is a function of occupancy only, never of deq_ready_i, so a full
    // queue refuses the enqueue even when decode drains in the same cycle.
    assign enq_ready_o = (count_q != FULL_CNT) && !flush_i;
    assign deq_valid_o = (count_q != '0) && !flush_i;
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign deq_fire    = deq_valid_o && deq_ready_i;
    assign count_o     = count_q;

    // Invalid head presents an addi x0,x0,0 so decode and the immediate
    // generator see a harmless instruction rather than stale storage.
    always_comb begin
        deq_instr_o      = NOP_INSTR;
        deq_pc_o         = '0;
        deq_pred_taken_o = 1'b0;
        if (deq_valid_o) begin
            deq_instr_o      = instr_mem_q[head_q];
            deq_pc_o         = pc_mem_q[head_q];
            deq_pred_taken_o = taken_mem_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PTR_ONE;
            if (deq_fire) head_d = head_q + PTR_ONE;
            if (enq_fire && !deq_fire) begin
                count_d = count_q + CNT_ONE;
            end else if (!enq_fire && deq_fire) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            instr_mem_q[tail_q] <= enq_instr_i;
            pc_mem_q[tail_q]    <= enq_pc_i;
            taken_mem_q[tail_q] <= enq_pred_taken_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares on every dequeue handshake.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        enq_valid_i;
    logic        enq_ready_o;
    logic [31:0] enq_instr_i;
    logic [31:0] enq_pc_i;
    logic        enq_pred_taken_i;
    logic        deq_valid_o;
    logic        deq_ready_i;
    logic [31:0] deq_instr_o;
    logic [31:0] deq_pc_o;
    logic        deq_pred_taken_o;
    logic [2:0]  count_o;

    fetch_queue #(.DEPTH(4), .PTR_W(2), .NOP_INSTR(32'h0000_0013)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .enq_valid_i     (enq_valid_i),
        .enq_ready_o     (enq_ready_o),
        .enq_instr_i     (enq_instr_i),
        .enq_pc_i        (enq_pc_i),
        .enq_pred_taken_i(enq_pred_taken_i),
        .deq_valid_o     (deq_valid_o),
        .deq_ready_i     (deq_ready_i),
        .deq_instr_o     (deq_instr_o),
        .deq_pc_o        (deq_pc_o),
        .deq_pred_taken_o(deq_pred_taken_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pop  = 0;

    logic [64:0] sb [$];

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [64:0] pack(input logic [31:0] instr, input logic [31:0] pc,
                                         input logic tk);
        return {instr, pc, tk};
    endfunction

    // Monitor: compare each dequeued entry against the scoreboard head and
    // check that a stalled head does not change.
    logic        stall_prev = 1'b0;
    logic [64:0] stall_val  = '0;
    always @(negedge clk_i) begin
        logic [64:0] cur;
        logic [64:0] exp;
        cur = pack(deq_instr_o, deq_pc_o, deq_pred_taken_o);
        if (!rst_ni) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && deq_valid_o) chk("stall_hold", cur, stall_val);
            if (deq_valid_o && deq_ready_i) begin
                n_pop++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL deq_unexpected: got %h expected no entry at %0t", cur, $time);
                end else begin
                    exp = sb.pop_front();
                    chk("deq_entry", cur, exp);
                end
            end
            stall_prev = deq_valid_o && !deq_ready_i;
            stall_val  = cur;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_enq(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                             input logic tk);
        enq_valid_i      = v;
        enq_pc_i         = pc;
        enq_instr_i      = instr;
        enq_pred_taken_i = tk;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        int          exp_cnt;
        int          sent;
        int          cyc;
        int          pops_before;
        logic        ef, df;
        logic [31:0] ins;

        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        deq_ready_i = 1'b0;
        drive_enq(1'b0, 32'h0, 32'h0, 1'b0);

        // 1: reset values, during and after reset
        #2;
        chk("rst_count", 65'(count_o), 65'(0));
        chk("rst_deq_valid", 65'(deq_valid_o), 65'(0));
        chk("rst_enq_ready", 65'(enq_ready_o), 65'(1));
        chk("rst_head", pack(deq_instr_o, deq_pc_o, deq_pred_taken_o), pack(NOP, 32'h0, 1'b0));
        #10 rst_ni = 1'b1;
        step();
        chk("idle_deq_valid", 65'(deq_valid_o), 65'(0));
        chk("idle_enq_ready", 65'(enq_ready_o), 65'(1));
        chk("idle_count", 65'(count_o), 65'(0));
        chk("idle_head", pack(deq_instr_o, deq_pc_o, deq_pred_taken_o), pack(NOP, 32'h0, 1'b0));

        // 2: fill with decode stalled, refuse 5th, then drain
        for (int i = 0; i < 4; i++) begin
            ins = 32'h0050_0093 + (32'(i) << 20);
            drive_enq(1'b1, 32'(i * 4), ins, i[0]);
            #2;
            chk("fill_ready", 65'(enq_ready_o), 65'(1));
            if (i == 0) chk("no_bypass", 65'(deq_valid_o), 65'(0));
            sb.push_back(pack(ins, 32'(i * 4), i[0]));
            step();
            if (i == 0) begin
                chk("fwft_valid", 65'(deq_valid_o), 65'(1));
                chk("fwft_head", pack(deq_instr_o, deq_pc_o, deq_pred_taken_o),
                    pack(32'h0050_0093, 32'h0, 1'b0));
            end
        end
        drive_enq(1'b1, 32'h10, 32'h0090_0093, 1'b1);
        #2;
        chk("full_count", 65'(count_o), 65'(4));
        chk("full_ready", 65'(enq_ready_o), 65'(0));
        step();
        chk("refused_count", 65'(count_o), 65'(4));
        drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
        deq_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drained_count", 65'(count_o), 65'(0));
        chk("drained_valid", 65'(deq_valid_o), 65'(0));

        // 3: concurrent enq/deq at count 2
        deq_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_enq(1'b1, 32'h40 + 32'(i * 4), 32'h1000_0013 + 32'(i), 1'b0);
            sb.push_back(pack(32'h1000_0013 + 32'(i), 32'h40 + 32'(i * 4), 1'b0));
            step();
        end
        deq_ready_i = 1'b1;
        for (int i = 2; i < 8; i++) begin
            drive_enq(1'b1, 32'h40 + 32'(i * 4), 32'h1000_0013 + 32'(i), i[0]);
            sb.push_back(pack(32'h1000_0013 + 32'(i), 32'h40 + 32'(i * 4), i[0]));
            #2;
            chk("conc_count", 65'(count_o), 65'(2));
            step();
        end
        chk("conc_count_end", 65'(count_o), 65'(2));
        drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        chk("conc_drained", 65'(count_o), 65'(0));
        deq_ready_i = 1'b0;

        // 4: flush while full
        for (int i = 0; i < 4; i++) begin
            drive_enq(1'b1, 32'h80 + 32'(i * 4), 32'h2000_0013 + 32'(i), 1'b1);
            sb.push_back(pack(32'h2000_0013 + 32'(i), 32'h80 + 32'(i * 4), 1'b1));
            step();
        end
        chk("pre_flush_count", 65'(count_o), 65'(4));
        flush_i     = 1'b1;
        deq_ready_i = 1'b1;
        drive_enq(1'b1, 32'h90, 32'h2000_0099, 1'b0);
        #2;
        chk("flush_deq_valid", 65'(deq_valid_o), 65'(0));
        chk("flush_enq_ready", 65'(enq_ready_o), 65'(0));
        sb.delete();
        step();
        flush_i = 1'b0;
        deq_ready_i = 1'b0;
        drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("post_flush_count", 65'(count_o), 65'(0));
        chk("post_flush_head", pack(deq_instr_o, deq_pc_o, deq_pred_taken_o),
            pack(NOP, 32'h0, 1'b0));
        drive_enq(1'b1, 32'h100, 32'h3000_0013, 1'b1);
        sb.push_back(pack(32'h3000_0013, 32'h100, 1'b1));
        step();
        drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
        chk("after_flush_head", pack(deq_instr_o, deq_pc_o, deq_pred_taken_o),
            pack(32'h3000_0013, 32'h100, 1'b1));
        deq_ready_i = 1'b1;
        step();
        deq_ready_i = 1'b0;

        // 5: wrap-around with a fixed stall pattern, checked against a count model
        pat         = 16'b1001_1100_0100_1101;
        exp_cnt     = 0;
        sent        = 0;
        cyc         = 0;
        pops_before = n_pop;
        while ((sent < 10 || exp_cnt != 0) && cyc < 80) begin
            ins = 32'h0000_0093 | (32'(sent) << 20);
            drive_enq(sent < 10, 32'(sent * 4), ins, sent[1]);
            deq_ready_i = pat[cyc % 16];
            #2;
            chk("wrap_ready", 65'(enq_ready_o), 65'(exp_cnt != 4));
            chk("wrap_count", 65'(count_o), 65'(exp_cnt));
            ef = (sent < 10) && (exp_cnt != 4);
            df = (exp_cnt != 0) && deq_ready_i;
            if (ef) begin
                sb.push_back(pack(ins, 32'(sent * 4), sent[1]));
                sent++;
            end
            if (ef && !df) exp_cnt++;
            else if (!ef && df) exp_cnt--;
            step();
            cyc++;
        end
        if (cyc >= 80) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wrap_timeout: got %0d cycles expected under 80", cyc);
        end
        drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
        deq_ready_i = 1'b0;
        chk("wrap_pops", 65'(n_pop - pops_before), 65'(10));

        // 6: asynchronous reset mid-stream at count 3
        for (int i = 0; i < 3; i++) begin
            drive_enq(1'b1, 32'h200 + 32'(i * 4), 32'h4000_0013 + 32'(i), 1'b0);
            sb.push_back(pack(32'h4000_0013 + 32'(i), 32'h200 + 32'(i * 4), 1'b0));
            step();
        end
        drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("pre_rst_count", 65'(count_o), 65'(3));
        rst_ni = 1'b0;
        #1;
        chk("async_rst_count", 65'(count_o), 65'(0));
        chk("async_rst_valid", 65'(deq_valid_o), 65'(0));
        chk("async_rst_ready", 65'(enq_ready_o), 65'(1));
        sb.delete();
        #1 rst_ni = 1'b1;
        step();
        chk("post_rst_count", 65'(count_o), 65'(0));

        step();
        chk("sb_empty", 65'(sb.size()), 65'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
